// File: rtl/serial_pkg.sv
// Shared serial-line definitions for the transmit and receive sides.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_piso_if.sv
// Parallel word handshake into the serial transmitter.
interface serial_tx_piso_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bit_tick_counter.sv
// Bit-period timer: pulses tick on the last cycle of each serial bit.
module bit_tick_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] r_cnt;

  // Count cycles within a bit; held at zero while disabled so the first bit starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!enable || (r_cnt == LAST_TICK)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign tick = enable && (r_cnt == LAST_TICK);
endmodule

// File: rtl/serial_tx_piso.sv
// Framed serial transmitter: start bit 0, WIDTH data bits LSB first, stop bit 1.
module serial_tx_piso
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_tx_piso_if.slave      tx_in,
  output logic                 txd,
  output logic                 busy,
  output logic                 done
);
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  tx_state_t        r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BCW-1:0]   r_bit_cnt;
  logic             r_txd;
  logic             r_done;

  logic             w_tick;
  logic             w_accept;
  logic             w_active;
  logic [WIDTH-1:0] w_shift_next;

  assign w_active     = (r_state != IDLE);
  assign w_accept     = tx_in.in_valid && (r_state == IDLE);
  assign w_shift_next = r_shift >> 1;

  bit_tick_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (w_active),
    .tick   (w_tick)
  );

  // Frame sequencer; txd is loaded one edge ahead so the line is a pure register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_txd     <= LINE_IDLE;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift   <= tx_in.in_data;
            r_bit_cnt <= '0;
            r_txd     <= START_BIT;
            r_state   <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_txd   <= r_shift[0];
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= w_shift_next;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              r_txd     <= STOP_BIT;
              r_state   <= STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BCW'(1);
              r_txd     <= w_shift_next[0];
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_txd   <= LINE_IDLE;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_in.in_ready = (r_state == IDLE);
  assign busy           = w_active;
  assign txd            = r_txd;
  assign done           = r_done;
endmodule
